// File: rtl/seq_tx.sv
// Serial pattern transmitter: shifts a captured WIDTH-bit pattern out MSB first, one bit per
// bit_en_i strobe, with repeat count, abort and start/busy/done handshake. SEQ_TX_PARITY_EN appends even parity.
module seq_tx #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned REP_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] pat_i,
  input  logic [REP_W-1:0] rep_i,
  input  logic             bit_en_i,
  input  logic             abort_i,
  output logic             dout_o,
  output logic             dvalid_o,
  output logic             last_o,
  output logic             busy_o,
  output logic             done_o
);

`ifdef SEQ_TX_PARITY_EN
  localparam int unsigned SH_W = WIDTH + 1;
`else
  localparam int unsigned SH_W = WIDTH;
`endif
  localparam int unsigned CNT_W = $clog2(SH_W);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(SH_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_pat;
  logic [SH_W-1:0]  r_sh;
  logic [REP_W-1:0] r_rep;
  logic [CNT_W-1:0] r_bit;

  logic [SH_W-1:0]  w_load;
  logic [SH_W-1:0]  w_reload;
  logic             w_start;
  logic             w_adv;
  logic             w_final;

  // Parity rides in the shift register's LSB so it leaves right after the pattern LSB
`ifdef SEQ_TX_PARITY_EN
  assign w_load   = {pat_i, ^pat_i};
  assign w_reload = {r_pat, ^r_pat};
`else
  assign w_load   = pat_i;
  assign w_reload = r_pat;
`endif

  assign w_start = (r_state == S_IDLE) && start_i;
  assign w_adv   = (r_state == S_SEND) && bit_en_i && !abort_i;
  assign w_final = (r_bit == '0) && (r_rep == '0);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    dout_o   = 1'b0;
    dvalid_o = 1'b0;
    last_o   = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next = S_SEND;
        end
      end
      S_SEND: begin
        busy_o   = 1'b1;
        dout_o   = r_sh[SH_W-1];
        dvalid_o = bit_en_i;
        last_o   = bit_en_i && w_final;
        if (abort_i) begin
          w_next = S_IDLE;
        end else if (bit_en_i && w_final) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: capture on accepted start, shift or reload the next frame on each strobe
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_pat <= '0;
      r_sh  <= '0;
      r_rep <= '0;
      r_bit <= '0;
    end else if (w_start) begin
      r_pat <= pat_i;
      r_sh  <= w_load;
      r_rep <= rep_i;
      r_bit <= BIT_LAST;
    end else if (w_adv) begin
      if (r_bit != '0) begin
        r_sh  <= {r_sh[SH_W-2:0], 1'b0};
        r_bit <= r_bit - CNT_W'(1);
      end else if (r_rep != '0) begin
        r_rep <= r_rep - REP_W'(1);
        r_sh  <= w_reload;
        r_bit <= BIT_LAST;
      end
    end
  end

endmodule

// File: tb/tb_seq_tx.sv
// Directed self-checking bench for seq_tx; outputs compared as {dout,dvalid,last,busy,done}.
module tb_seq_tx;

`ifdef SEQ_TX_PARITY_EN
  localparam int FL = 7;
  localparam logic [6:0] EXPA = 7'b1010110;
  localparam logic [6:0] EXPB = 7'b1010101;
`else
  localparam int FL = 6;
  localparam logic [6:0] EXPA = 7'b0101011;
  localparam logic [6:0] EXPB = 7'b0101010;
`endif

  logic       clk;
  logic       reset_i;
  logic       start_i;
  logic [5:0] pat_i;
  logic [3:0] rep_i;
  logic       bit_en_i;
  logic       abort_i;
  logic       dout_o;
  logic       dvalid_o;
  logic       last_o;
  logic       busy_o;
  logic       done_o;
  logic [4:0] obs;
  int n_checks;
  int n_errors;

  seq_tx #(.WIDTH(6), .REP_W(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .pat_i(pat_i), .rep_i(rep_i),
    .bit_en_i(bit_en_i), .abort_i(abort_i), .dout_o(dout_o), .dvalid_o(dvalid_o),
    .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
  );

  assign obs = {dout_o, dvalid_o, last_o, busy_o, done_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    @(negedge clk);
    bit_en_i = 1'b1;
    start_i  = 1'b1;
    #1;
    n_checks++;
    if (obs !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 5'b0);
    end
    reset_i  = 1'b1;
    start_i  = 1'b0;
    bit_en_i = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (obs !== 5'b0) begin
      n_errors++;
      $display("FAIL idle_after_reset: got %b expected %b", obs, 5'b0);
    end
  endtask

  task automatic test_basic;
    logic [4:0] exp;
    @(negedge clk);
    start_i = 1'b1; pat_i = 6'b101011; rep_i = 4'd0; bit_en_i = 1'b0; abort_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 5'b0) begin
      n_errors++;
      $display("FAIL basic_start_cycle: got %b expected %b", obs, 5'b0);
    end
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      start_i = 1'b0; bit_en_i = 1'b1;
      #1;
      exp = {EXPA[FL-1-k], 1'b1, (k == FL-1), 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL basic_bit%0d: got %b expected %b", k, obs, exp);
      end
    end
    @(negedge clk);
    bit_en_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 5'b00011) begin
      n_errors++;
      $display("FAIL basic_done: got %b expected %b", obs, 5'b00011);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (obs !== 5'b0) begin
      n_errors++;
      $display("FAIL basic_idle: got %b expected %b", obs, 5'b0);
    end
  endtask

  task automatic test_repeat;
    logic [4:0] exp;
    @(negedge clk);
    start_i = 1'b1; pat_i = 6'b101011; rep_i = 4'd2; bit_en_i = 1'b0;
    #1;
    for (int b = 0; b < 3*FL; b++) begin
      for (int p = 0; p < 3; p++) begin
        @(negedge clk);
        start_i = 1'b0; bit_en_i = (p == 2);
        #1;
        exp = {EXPA[FL-1-(b % FL)], (p == 2), (p == 2 && b == 3*FL-1), 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp) begin
          n_errors++;
          $display("FAIL repeat_bit%0d_phase%0d: got %b expected %b", b, p, obs, exp);
        end
      end
    end
    @(negedge clk);
    bit_en_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 5'b00011) begin
      n_errors++;
      $display("FAIL repeat_done: got %b expected %b", obs, 5'b00011);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (obs !== 5'b0) begin
      n_errors++;
      $display("FAIL repeat_idle: got %b expected %b", obs, 5'b0);
    end
  endtask

  task automatic test_abort;
    logic [4:0] exp;
    @(negedge clk);
    start_i = 1'b1; pat_i = 6'b101011; rep_i = 4'd0; bit_en_i = 1'b0; abort_i = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start_i = 1'b0; bit_en_i = 1'b1; abort_i = (k == 2);
      #1;
      exp = {EXPA[FL-1-k], 1'b1, 1'b0, 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL abort_bit%0d: got %b expected %b", k, obs, exp);
      end
    end
    @(negedge clk);
    abort_i = 1'b0; bit_en_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 5'b0) begin
      n_errors++;
      $display("FAIL abort_idle: got %b expected %b", obs, 5'b0);
    end
    // start with abort in IDLE is still accepted
    @(negedge clk);
    start_i = 1'b1; abort_i = 1'b1;
    #1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    #1;
    exp = {EXPA[FL-1], 1'b0, 1'b0, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL abort_idle_start: got %b expected %b", obs, exp);
    end
    @(negedge clk);
    abort_i = 1'b1;
    #1;
    @(negedge clk);
    abort_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 5'b0) begin
      n_errors++;
      $display("FAIL abort_hold_idle: got %b expected %b", obs, 5'b0);
    end
    test_basic();
  endtask

  task automatic test_start_ignored;
    logic [4:0] exp;
    @(negedge clk);
    start_i = 1'b1; pat_i = 6'b101010; rep_i = 4'd0; bit_en_i = 1'b0;
    #1;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      start_i = 1'b1; pat_i = 6'b111111; rep_i = 4'hF; bit_en_i = 1'b1;
      #1;
      exp = {EXPB[FL-1-k], 1'b1, (k == FL-1), 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL ignore_bit%0d: got %b expected %b", k, obs, exp);
      end
    end
    @(negedge clk);
    bit_en_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 5'b00011) begin
      n_errors++;
      $display("FAIL ignore_done: got %b expected %b", obs, 5'b00011);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      #1;
      n_checks++;
      if (obs !== 5'b0) begin
        n_errors++;
        $display("FAIL ignore_no_queue%0d: got %b expected %b", c, obs, 5'b0);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [4:0] exp;
    @(negedge clk);
    start_i = 1'b1; pat_i = 6'b101011; rep_i = 4'd1; bit_en_i = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start_i = 1'b0; bit_en_i = 1'b1;
      #1;
    end
    exp = {EXPA[FL-3], 1'b1, 1'b0, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL rstmid_pre: got %b expected %b", obs, exp);
    end
    #1;
    reset_i = 1'b0;
    #1;
    n_checks++;
    if (obs !== 5'b0) begin
      n_errors++;
      $display("FAIL rstmid_async: got %b expected %b", obs, 5'b0);
    end
    @(negedge clk);
    #1;
    reset_i = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (obs !== 5'b0) begin
      n_errors++;
      $display("FAIL rstmid_idle: got %b expected %b", obs, 5'b0);
    end
    bit_en_i = 1'b0;
  endtask

  task automatic test_max_rep;
    int strobes;
    int lasts;
    int last_at;
    bit seen_done;
    strobes = 0; lasts = 0; last_at = -1; seen_done = 1'b0;
    @(negedge clk);
    start_i = 1'b1; pat_i = 6'b101011; rep_i = 4'hF; bit_en_i = 1'b1;
    #1;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 0; c < 16*FL + 10 && !seen_done; c++) begin
      #1;
      if (dvalid_o) strobes++;
      if (last_o) begin
        lasts++;
        last_at = strobes;
      end
      if (done_o) seen_done = 1'b1;
      @(negedge clk);
    end
    bit_en_i = 1'b0;
    n_checks++;
    if (!seen_done) begin
      n_errors++;
      $display("FAIL maxrep_done: done_o never seen within %0d cycles", 16*FL + 10);
    end
    n_checks++;
    if (strobes !== 16*FL) begin
      n_errors++;
      $display("FAIL maxrep_bits: got %0d expected %0d", strobes, 16*FL);
    end
    n_checks++;
    if (lasts !== 1 || last_at !== 16*FL) begin
      n_errors++;
      $display("FAIL maxrep_last: got count %0d at %0d expected 1 at %0d", lasts, last_at, 16*FL);
    end
    #1;
    n_checks++;
    if (obs !== 5'b0) begin
      n_errors++;
      $display("FAIL maxrep_idle: got %b expected %b", obs, 5'b0);
    end
  endtask

  task automatic test_back_to_back;
    localparam int P = FL + 2;
    logic [4:0] exp;
    int dones;
    int k;
    dones = 0;
    for (int c = 0; c < 3*P; c++) begin
      @(negedge clk);
      start_i = 1'b1; pat_i = 6'b101011; rep_i = 4'd0; bit_en_i = 1'b1;
      #1;
      k = (c % P) - 1;
      if (c % P == 0) exp = 5'b0;
      else if (c % P == P-1) exp = 5'b00011;
      else exp = {EXPA[FL-1-k], 1'b1, (k == FL-1), 1'b1, 1'b0};
      if (done_o) dones++;
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL b2b_cycle%0d: got %b expected %b", c, obs, exp);
      end
    end
    @(negedge clk);
    start_i = 1'b0; bit_en_i = 1'b0;
    #1;
    n_checks++;
    if (dones !== 3) begin
      n_errors++;
      $display("FAIL b2b_done_count: got %0d expected 3", dones);
    end
    n_checks++;
    if (obs !== 5'b0) begin
      n_errors++;
      $display("FAIL b2b_idle: got %b expected %b", obs, 5'b0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_i  = 1'b0;
    start_i  = 1'b0;
    pat_i    = '0;
    rep_i    = '0;
    bit_en_i = 1'b0;
    abort_i  = 1'b0;
    test_reset();
    test_basic();
    test_repeat();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    test_max_rep();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_tx.md
Name: seq_tx

Overview:
- Serial pattern transmitter: the driving end of the serial bit-stream sequence detectors used in the lab designs.
- Captures a WIDTH-bit pattern and shifts it out MSB first, one bit per bit_en_i strobe, with a valid qualifier the detector samples on.
- Supports a programmable repeat count, a synchronous abort, and start/busy/done handshaking to the controlling logic.

Parameters:
- WIDTH, 6, pattern length in bits (>=2).
- REP_W, 4, width of repeat-count input.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- reset_i  input  1  asynchronous reset, active-low.
- start_i  input  1  start request; sampled only in IDLE.
- pat_i  input  WIDTH  pattern, captured on accepted start.
- rep_i  input  REP_W  extra repeats, captured on accepted start; total frames = rep_i+1.
- bit_en_i  input  1  bit-rate strobe; one bit advances per high cycle.
- abort_i  input  1  synchronous abort.
- dout_o  output  1  serial data.
- dvalid_o  output  1  dout_o is valid this cycle; equals bit_en_i while in SEND.
- last_o  output  1  final bit of final frame is being transmitted.
- busy_o  output  1  high in SEND and DONE.
- done_o  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset_i=0, asynchronous): state=IDLE, shift/pattern registers=0, counters=0; all outputs 0.
- State register: IDLE, SEND, DONE.
- IDLE:
  - All outputs 0.
  - start_i=1 -> pat_reg<=pat_i, shreg<=pat_i, rep_cnt<=rep_i, bit_cnt<=WIDTH-1; next state SEND.
  - start_i has no effect in any other state; no queuing.
- SEND:
  - dout_o=shreg[MSB] combinationally; busy_o=1; dvalid_o=bit_en_i.
  - On bit_en_i=1 with bit_cnt!=0: shreg shifts left (0 in), bit_cnt--.
  - On bit_en_i=1 with bit_cnt==0 and rep_cnt!=0: rep_cnt--, shreg<=pat_reg, bit_cnt<=WIDTH-1. No idle bit between frames.
  - On bit_en_i=1 with bit_cnt==0 and rep_cnt==0: next state DONE.
  - last_o = bit_en_i & bit_cnt==0 & rep_cnt==0.
  - bit_en_i=0: all state held; dout_o stays stable.
- DONE: done_o=1, busy_o=1, dout_o=0; next state IDLE unconditionally. Earliest restart is the cycle after DONE.
- abort_i=1 in SEND or DONE: next state IDLE, no done_o pulse. Abort has priority over bit_en_i in the same cycle.
- abort_i in IDLE: ignored. If start_i=1 in the same cycle, start is still accepted.
- Latency: first bit valid the cycle after start is accepted. Frame of N strobes -> done_o the cycle after the final strobe.
- Reset mid-transfer: immediate return to IDLE, outputs 0; the partial frame is lost.
- rep_i = max (2^REP_W-1): 2^REP_W frames, no wrap of rep_cnt.

Optional Feature:
- Macro: SEQ_TX_PARITY_EN.
- Defined:
  - Each frame carries WIDTH+1 bits; the appended bit is the even parity (XOR) of pat_reg, sent after the LSB.
  - bit_cnt spans WIDTH..0.
  - last_o marks the parity bit of the final frame.
  - Repeats also carry parity.
- Undefined: WIDTH bits per frame; no parity logic present.

Test Plan:
- Basic frame: reset, pat_i=6'b101011, rep_i=0, start, bit_en_i every cycle -> dout_o=1,0,1,0,1,1 with dvalid_o=1; last_o on 6th bit; done_o one cycle later; busy_o high 7 cycles.
- Repeat: pat_i=6'b101011, rep_i=2, bit_en_i every 3rd cycle -> 18 valid bits, pattern back-to-back three times, dout_o stable between strobes; last_o only on bit 18; one done_o.
- Abort: start, abort_i asserted alongside the 3rd strobe -> IDLE next cycle, busy_o=0, no done_o, 3rd bit not counted; new start then sends a full frame.
- Start ignored and reset mid-frame: start_i pulsed during SEND -> no effect, frame completes unchanged; reset_i low mid-frame -> all outputs 0 asynchronously, IDLE after release.
- Parity (SEQ_TX_PARITY_EN defined): pat_i=6'b101011 -> 7 bits 1,0,1,0,1,1,0. pat_i=6'b101010 -> final bit 1.
- Back-to-back: start_i held high continuously, rep_i=0 -> frames separated by exactly DONE+IDLE cycles; done_o pulses once per frame.
